// File: rtl/escalonador_demux8.sv
// Sequencer for the 8-way byte demux: buffers one upstream byte, picks a target
// channel (round-robin over enabled channels or a fixed address) and holds it until accepted.

module escalonador_demux8_chk (
  input logic       clk,
  input logic       rst,
  input logic [7:0] valido_saida,
  input logic       ocupado,
  input logic       pronto_in,
  input logic       erro_mascara
);

  // At most one sink sees valid at a time
  a_valido_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(valido_saida));

  // Busy and ready are exact complements
  a_ocupado_pronto: assert property (@(posedge clk) disable iff (rst) ocupado != pronto_in);

  // A mask error never coexists with an outstanding delivery
  a_erro_sem_valido: assert property (@(posedge clk) disable iff (rst)
                                      erro_mascara |-> (valido_saida == 8'h00));

endmodule

module escalonador_demux8 #(
  parameter int LARGURA_DADOS = 8,
  parameter int LARGURA_CONT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LARGURA_DADOS-1:0] dados_in,
  input  logic                     valido_in,
  output logic                     pronto_in,
  input  logic                     modo_fixo,
  input  logic [2:0]               endereco_fixo,
  input  logic [7:0]               mascara,
  output logic [LARGURA_DADOS-1:0] dados,
  output logic [2:0]               endereco,
  output logic [7:0]               valido_saida,
  input  logic [7:0]               pronto_saida,
  output logic                     ocupado,
  output logic                     erro_mascara,
  output logic [LARGURA_CONT-1:0]  contador_envios
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCOLHE = 2'd1,
    ENVIA   = 2'd2
  } estado_t;

  estado_t                  estado_q, estado_d;
  logic [LARGURA_DADOS-1:0] dados_q, dados_d;
  logic [2:0]               endereco_q, endereco_d;
  logic [2:0]               ponteiro_q, ponteiro_d;
  logic [7:0]               valido_saida_q, valido_saida_d;
  logic                     ocupado_q, ocupado_d;
  logic                     pronto_in_q, pronto_in_d;
  logic                     erro_q, erro_d;
  logic [LARGURA_CONT-1:0]  cont_q, cont_d;

  logic                     alvo_ok_s;
  logic [2:0]               alvo_s;

  // First enabled channel after ptr, wrapping; ptr itself has the lowest priority.
  function automatic logic [3:0] busca_rr(input logic [7:0] msk, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'b0000;
    for (int k = 8; k >= 1; k--) begin
      cand = ptr + 3'(k);
      if (msk[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] um_quente(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Target selection from the current mode, mask and last served channel
  always_comb begin
    alvo_ok_s = 1'b0;
    alvo_s    = 3'd0;
    if (modo_fixo) begin
      alvo_s    = endereco_fixo;
      alvo_ok_s = mascara[endereco_fixo];
    end else begin
      {alvo_ok_s, alvo_s} = busca_rr(mascara, ponteiro_q);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_d       = estado_q;
    dados_d        = dados_q;
    endereco_d     = endereco_q;
    ponteiro_d     = ponteiro_q;
    valido_saida_d = valido_saida_q;
    cont_d         = cont_q;
    erro_d         = 1'b0;
    case (estado_q)
      OCIOSO: begin
        valido_saida_d = 8'h00;
        if (valido_in) begin
          dados_d  = dados_in;
          estado_d = ESCOLHE;
        end else begin
          estado_d = OCIOSO;
        end
      end
      ESCOLHE: begin
        if (alvo_ok_s) begin
          endereco_d     = alvo_s;
          valido_saida_d = um_quente(alvo_s);
          estado_d       = ENVIA;
        end else begin
          erro_d   = 1'b1;
          estado_d = ESCOLHE;
        end
      end
      ENVIA: begin
        // Only the selected sink's ready completes the delivery
        if (pronto_saida[endereco_q]) begin
          cont_d         = cont_q + {{(LARGURA_CONT-1){1'b0}}, 1'b1};
          ponteiro_d     = endereco_q;
          valido_saida_d = 8'h00;
          estado_d       = OCIOSO;
        end else begin
          estado_d = ENVIA;
        end
      end
      default: begin
        valido_saida_d = 8'h00;
        estado_d       = OCIOSO;
      end
    endcase
    ocupado_d   = (estado_d != OCIOSO);
    pronto_in_d = (estado_d == OCIOSO);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q       <= OCIOSO;
      dados_q        <= {LARGURA_DADOS{1'b0}};
      endereco_q     <= 3'd0;
      ponteiro_q     <= 3'd7;
      valido_saida_q <= 8'h00;
      ocupado_q      <= 1'b0;
      pronto_in_q    <= 1'b1;
      erro_q         <= 1'b0;
      cont_q         <= {LARGURA_CONT{1'b0}};
    end else begin
      estado_q       <= estado_d;
      dados_q        <= dados_d;
      endereco_q     <= endereco_d;
      ponteiro_q     <= ponteiro_d;
      valido_saida_q <= valido_saida_d;
      ocupado_q      <= ocupado_d;
      pronto_in_q    <= pronto_in_d;
      erro_q         <= erro_d;
      cont_q         <= cont_d;
    end
  end

  assign pronto_in       = pronto_in_q;
  assign dados           = dados_q;
  assign endereco        = endereco_q;
  assign valido_saida    = valido_saida_q;
  assign ocupado         = ocupado_q;
  assign erro_mascara    = erro_q;
  assign contador_envios = cont_q;

  escalonador_demux8_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .valido_saida (valido_saida_q),
    .ocupado      (ocupado_q),
    .pronto_in    (pronto_in_q),
    .erro_mascara (erro_q)
  );

endmodule
